// File: rtl/serial_link_pkg.sv
// Shared types and default timing constants for the serial link controller.
package serial_link_pkg;

    localparam int DEF_CLK_DIV      = 16;
    localparam int DEF_FRAME_BITS   = 10;
    localparam int DEF_GUARD_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_START  = 3'd1,
        RX_ACTIVE = 3'd2,
        TX_LOAD   = 3'd3,
        TX_ACTIVE = 3'd4,
        GUARD     = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period divider: tick is high for one cycle every DIV cycles, counting from clear.
module baud_tick_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    assign tick = (cnt_q == LAST);

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_link_ctrl.sv
// Half-duplex serial link controller: start-bit qualification, RX/TX bit strobes, guard gap.
// Optional stop-bit checking is enabled by defining FRAME_ERR_EN.
module serial_link_ctrl
    import serial_link_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int FRAME_BITS   = DEF_FRAME_BITS,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_line,
    input  logic tx_req,
    output logic sr_clk,
    output logic rec_en,
    output logic trans_en,
    output logic tx_load,
    output logic tx_ack,
    output logic char_rec,
    output logic tx_done,
    output logic frame_err,
    output logic busy
);

    localparam int HALF    = CLK_DIV / 2;
    localparam int CNT_MAX = max3(FRAME_BITS, GUARD_CYCLES, HALF);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(FRAME_BITS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             sr_clk_q, sr_clk_d;
    logic             rec_en_q, rec_en_d;
    logic             trans_en_q, trans_en_d;
    logic             tx_load_q, tx_load_d;
    logic             tx_ack_q, tx_ack_d;
    logic             char_rec_q, char_rec_d;
    logic             tx_done_q, tx_done_d;
    logic             busy_q, busy_d;
`ifdef FRAME_ERR_EN
    logic             frame_err_q, frame_err_d;
`endif

    logic tick;
    logic div_clear;

    baud_tick_gen #(
        .DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(div_clear),
        .tick (tick)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_clk_d   = 1'b0;
        char_rec_d = 1'b0;
        tx_done_d  = 1'b0;
`ifdef FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_line) begin
                    state_d = RX_START;
                end else if (tx_req) begin
                    state_d = TX_LOAD;
                end
            end
            RX_START: begin
                if (int'(bit_cnt_q) + 1 >= HALF) begin
                    state_d = rx_line ? IDLE : RX_ACTIVE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            RX_ACTIVE: begin
                // After the last strobe: report in the strobe's following cycle, then leave.
                if (bit_cnt_q == RX_LAST) begin
                    if (sr_clk_q) begin
`ifdef FRAME_ERR_EN
                        frame_err_d = !rx_line;
                        char_rec_d  = rx_line;
`else
                        char_rec_d  = 1'b1;
`endif
                    end else begin
                        state_d = GUARD;
                    end
                end else if (tick) begin
                    sr_clk_d  = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            TX_LOAD: begin
                state_d = TX_ACTIVE;
            end
            TX_ACTIVE: begin
                if (bit_cnt_q == TX_LAST) begin
                    if (sr_clk_q) begin
                        tx_done_d = 1'b1;
                    end else begin
                        state_d = GUARD;
                    end
                end else if (tick) begin
                    sr_clk_d  = 1'b1;
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            GUARD: begin
                if (int'(bit_cnt_q) + 1 >= GUARD_CYCLES) begin
                    state_d = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        div_clear = (state_d != state_q);
        if (div_clear) begin
            bit_cnt_d = '0;
        end

        rec_en_d   = (state_d == RX_ACTIVE);
        trans_en_d = (state_d == TX_ACTIVE);
        tx_load_d  = (state_d == TX_LOAD);
        tx_ack_d   = (state_d == TX_LOAD);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sr_clk_q   <= 1'b0;
            rec_en_q   <= 1'b0;
            trans_en_q <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_ack_q   <= 1'b0;
            char_rec_q <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_clk_q   <= sr_clk_d;
            rec_en_q   <= rec_en_d;
            trans_en_q <= trans_en_d;
            tx_load_q  <= tx_load_d;
            tx_ack_q   <= tx_ack_d;
            char_rec_q <= char_rec_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
`ifdef FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign sr_clk   = sr_clk_q;
    assign rec_en   = rec_en_q;
    assign trans_en = trans_en_q;
    assign tx_load  = tx_load_q;
    assign tx_ack   = tx_ack_q;
    assign char_rec = char_rec_q;
    assign tx_done  = tx_done_q;
    assign busy     = busy_q;
`ifdef FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: doc/serial_link_ctrl.md
SERIAL_LINK_CTRL -- requirements
Module: serial_link_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per serial bit, minimum 2, even.
REQ-002 SHALL have parameter FRAME_BITS, default 10: bits per frame (start + 8 data + stop).
REQ-003 SHALL have parameter GUARD_CYCLES, default 8: idle clk cycles enforced after every frame; 0 allowed.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  asynchronous reset, active-high.
REQ-007 rx_line  input  1  incoming serial line, idle high, synchronised upstream.
REQ-008 tx_req  input  1  local character ready; held high until tx_ack.
REQ-009 sr_clk  output  1  one-cycle bit strobe for the shift datapaths.
REQ-010 rec_en  output  1  receive datapath enable; high in RX_ACTIVE.
REQ-011 trans_en  output  1  transmit datapath enable; high in TX_ACTIVE.
REQ-012 tx_load  output  1  one-cycle parallel-load pulse to transmit shifter.
REQ-013 tx_ack  output  1  one-cycle acknowledge of tx_req, coincident with tx_load.
REQ-014 char_rec  output  1  one-cycle pulse: valid frame received.
REQ-015 tx_done  output  1  one-cycle pulse: frame transmitted.
REQ-016 frame_err  output  1  one-cycle pulse: stop bit sampled low (see Configuration).
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, RX_START, RX_ACTIVE, TX_LOAD, TX_ACTIVE, GUARD.
REQ-019 IDLE: rx_line low -> RX_START; else tx_req high -> TX_LOAD; receive wins when both occur same cycle.
REQ-020 RX_START: after CLK_DIV/2 cycles, rx_line low -> RX_ACTIVE, rx_line high -> IDLE (glitch, no outputs).
REQ-021 RX_ACTIVE: sr_clk pulses every CLK_DIV cycles, first pulse CLK_DIV cycles after entry; after FRAME_BITS-1 pulses -> GUARD.
REQ-022 char_rec SHALL pulse the cycle after the final RX sr_clk pulse.
REQ-023 TX_LOAD: one cycle, tx_load=tx_ack=1, -> TX_ACTIVE.
REQ-024 TX_ACTIVE: sr_clk every CLK_DIV cycles, first CLK_DIV cycles after entry; after FRAME_BITS pulses tx_done pulses next cycle and -> GUARD.
REQ-025 rx_line SHALL be ignored in TX_ACTIVE and GUARD; tx_req ignored outside IDLE.
REQ-026 GUARD: GUARD_CYCLES cycles then IDLE; GUARD_CYCLES=0 -> IDLE next cycle.
REQ-027 tx_req dropped before tx_ack SHALL produce no transmission.
REQ-028 Divider and bit counters SHALL clear on every state entry; no wrap beyond terminal counts.
REQ-029 sr_clk SHALL be low in IDLE, RX_START, TX_LOAD, GUARD.

Reset
REQ-030 rst high SHALL force IDLE, zero both counters, all outputs 0, immediately and asynchronously.
REQ-031 Reset mid-frame SHALL abort without char_rec, tx_done or frame_err pulses.

Configuration
REQ-032 With FRAME_ERR_EN defined: rx_line sampled at final RX sr_clk; low -> frame_err pulses instead of char_rec.
REQ-033 Without FRAME_ERR_EN: frame_err tied 0, char_rec always pulses at frame end.

Structure
REQ-034 Package serial_link_pkg SHALL hold the state enum and default CLK_DIV/FRAME_BITS/GUARD_CYCLES constants.
REQ-035 Divider SHALL be sub-module baud_tick_gen (clk, rst, clear, tick).

Verification (CLK_DIV=4, FRAME_BITS=10, GUARD_CYCLES=2)
REQ-036 Valid RX frame, stop high -> 9 sr_clk pulses 4 cycles apart, rec_en high throughout, one char_rec, busy low 3 cycles after char_rec.
REQ-037 rx_line low 1 cycle in IDLE -> back to IDLE after 2 cycles, no sr_clk, no char_rec.
REQ-038 tx_req held -> tx_load+tx_ack one cycle, 10 sr_clk pulses, tx_done, tx_req dropped after ack -> no second frame.
REQ-039 tx_req and rx_line falling same cycle -> RX frame first, TX starts after GUARD, tx_ack only then.
REQ-040 FRAME_ERR_EN, stop bit low -> frame_err pulse, no char_rec; without macro -> char_rec.
REQ-041 rst asserted at 5th TX sr_clk -> all outputs 0 same cycle, IDLE, no tx_done.
